bus_xfer_ctrl: RTL and testbench

Sequencer and arbiter for the shared 8-bit tri-state data bus that links the register file. Accepts register-to-register move requests from several requesters, picks one winner, and drives the one-hot `re` of the source register and `we` of the destination register so that exactly one register drives the bus per transfer. It sits between the control unit / instruction decoder requesters and the bank of `register` instances. It never touches the data bus itself.

---
 rtl/bus_xfer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// Arbiter and re/we sequencer for the shared 8-bit register bus: IDLE -> XFER -> ACK.
// Define BUS_XFER_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module bus_xfer_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int IDX_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] src_idx,
  input  logic [NUM_REQ*IDX_W-1:0] dst_idx,
  output logic [NUM_REG-1:0]       re,
  output logic [NUM_REG-1:0]       we,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     err,
  output logic                     busy
);

  localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] REG_LIM = (IDX_W+1)'(NUM_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               any_req;
  logic [WIN_W-1:0]   win_c;
  logic [IDX_W-1:0]   src_c;
  logic [IDX_W-1:0]   dst_c;

  logic [WIN_W-1:0]   win_p0;
  logic [IDX_W-1:0]   src_p0;
  logic [IDX_W-1:0]   dst_p0;
  logic               legal_p0;

  logic [NUM_REG-1:0] re_nxt;
  logic [NUM_REG-1:0] we_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               err_nxt;
  logic               busy_nxt;

  function automatic logic move_legal(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d);
    return (s != d) && ({1'b0, s} < REG_LIM) && ({1'b0, d} < REG_LIM);
  endfunction

  function automatic logic [NUM_REG-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REG-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      if (idx == IDX_W'(r)) v[r] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [WIN_W-1:0] w);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w == WIN_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

`ifdef BUS_XFER_RR_EN
  logic [WIN_W-1:0]     ptr;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [WIN_W:0]       win_sum;

  // Rotate so the pointer position is bit 0, take the lowest set bit, then un-rotate.
  always_comb begin
    any_req = 1'b0;
    win_sum = '0;
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req_rot[k]) begin
        any_req = 1'b1;
        win_sum = {1'b0, ptr} + (WIN_W+1)'(k);
      end
    end
    if (win_sum >= (WIN_W+1)'(NUM_REQ)) win_sum = win_sum - (WIN_W+1)'(NUM_REQ);
    win_c = win_sum[WIN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (state == ACK) begin
      ptr <= (win_p0 == WIN_W'(NUM_REQ-1)) ? '0 : win_p0 + WIN_W'(1);
    end
  end
`else
  always_comb begin
    any_req = 1'b0;
    win_c   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        win_c   = WIN_W'(k);
      end
    end
  end
`endif

  always_comb begin
    src_c = '0;
    dst_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_c == WIN_W'(i)) begin
        src_c = src_idx[i*IDX_W +: IDX_W];
        dst_c = dst_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  // Stage p0: winning request captured in IDLE, held through XFER and ACK
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      win_p0   <= win_c;
      src_p0   <= src_c;
      dst_p0   <= dst_c;
      legal_p0 <= move_legal(src_c, dst_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    re_nxt    = '0;
    we_nxt    = '0;
    gnt_nxt   = '0;
    err_nxt   = 1'b0;
    busy_nxt  = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) state_nxt = XFER;
      end
      XFER: begin
        state_nxt = ACK;
        if (legal_p0) begin
          re_nxt = reg_onehot(src_p0);
          we_nxt = reg_onehot(dst_p0);
        end
      end
      ACK: begin
        state_nxt = IDLE;
        gnt_nxt   = req_onehot(win_p0);
        err_nxt   = !legal_p0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: bus enables and handshake lag the state by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re   <= '0;
      we   <= '0;
      gnt  <= '0;
      err  <= 1'b0;
      busy <= 1'b0;
    end else begin
      re   <= re_nxt;
      we   <= we_nxt;
      gnt  <= gnt_nxt;
      err  <= err_nxt;
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl with a register-bank model on the bus.
// Honours BUS_XFER_RR_EN in its reference arbiter.
module tb_bus_xfer_ctrl;

  localparam int NUM_REQ = 4;
  localparam int NUM_REG = 8;
  localparam int IDX_W   = 3;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic               err;
    logic [NUM_REG-1:0] re;
    logic [NUM_REG-1:0] we;
    int                 cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] req_v;
  } chk_t;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*IDX_W-1:0] src_idx;
  logic [NUM_REQ*IDX_W-1:0] dst_idx;
  logic [NUM_REG-1:0]       re;
  logic [NUM_REG-1:0]       we;
  logic [NUM_REQ-1:0]       gnt;
  logic                     err;
  logic                     busy;

  exp_t exp_q[$];
  chk_t chk_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int s_arr[NUM_REQ];
  int d_arr[NUM_REQ];
`ifdef BUS_XFER_RR_EN
  int mptr = 0;
`endif

  logic             spacing_chk = 1'b0;
  logic             load_en = 1'b0;
  int               load_idx = 0;
  logic [7:0]       load_val = '0;
  logic [7:0]       regs[NUM_REG];
  logic [7:0]       bus;

  bus_xfer_ctrl #(.NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .req(req), .src_idx(src_idx), .dst_idx(dst_idx),
    .re(re), .we(we), .gnt(gnt), .err(err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank sharing the bus: re selects the driver, we captures at the edge
  always_comb begin
    bus = '0;
    for (int j = 0; j < NUM_REG; j++) begin
      if (re[j]) bus = regs[j];
    end
  end

  always @(posedge clk) begin
    if (load_en) begin
      regs[load_idx] <= load_val;
    end else begin
      for (int j = 0; j < NUM_REG; j++) begin
        if (we[j]) regs[j] <= bus;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Monitor: drains posted checks, watches invariants, pops the scoreboard on each gnt
  logic [NUM_REG-1:0] seen_re = '0;
  logic [NUM_REG-1:0] seen_we = '0;
  int   act_cyc = 0;
  logic have_prev = 1'b0;
  int   prev_cyc = 0;
  exp_t me;
  chk_t mc;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      check(mc.name, mc.act, mc.req_v);
    end
    check("re_onehot0", {31'b0, $onehot0(re)}, 32'd1);
    check("we_onehot0", {31'b0, $onehot0(we)}, 32'd1);
    if (!rst) begin
      seen_re   = '0;
      seen_we   = '0;
      act_cyc   = 0;
      have_prev = 1'b0;
    end else begin
      if (re != '0 || we != '0) begin
        seen_re |= re;
        seen_we |= we;
        act_cyc++;
      end
      if (gnt != '0) begin
        check("re_zero_with_gnt", 32'(re), 32'd0);
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          me = exp_q.pop_front();
          check("gnt", 32'(gnt), 32'(me.gnt));
          check("err", 32'(err), 32'(me.err));
          check("re_seen", 32'(seen_re), 32'(me.re));
          check("we_seen", 32'(seen_we), 32'(me.we));
          check("enable_cycles", 32'(act_cyc), 32'(me.cyc));
        end
        if (spacing_chk) begin
          if (have_prev) check("gnt_spacing", 32'(cyc - prev_cyc), 32'd3);
          have_prev = 1'b1;
          prev_cyc  = cyc;
        end else begin
          have_prev = 1'b0;
        end
        seen_re = '0;
        seen_we = '0;
        act_cyc = 0;
      end
    end
  end

  task automatic post(input string nm, input logic [31:0] a, input logic [31:0] x);
    chk_t c;
    c.name  = nm;
    c.act   = a;
    c.req_v = x;
    chk_q.push_back(c);
  endtask

  function automatic logic model_legal(input int s, input int d);
    return (s != d) && (s < NUM_REG) && (d < NUM_REG);
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] m);
`ifdef BUS_XFER_RR_EN
    int k;
    for (int n = 0; n < NUM_REQ; n++) begin
      k = (mptr + n) % NUM_REQ;
      if (((m >> k) & NUM_REQ'(1)) != '0) return k;
    end
`else
    for (int n = 0; n < NUM_REQ; n++) begin
      if (((m >> n) & NUM_REQ'(1)) != '0) return n;
    end
`endif
    return -1;
  endfunction

  task automatic push_exp(input int w);
    exp_t x;
    logic ok;
    ok    = model_legal(s_arr[w], d_arr[w]);
    x.gnt = NUM_REQ'(1) << w;
    x.err = !ok;
    x.re  = ok ? (NUM_REG'(1) << s_arr[w]) : '0;
    x.we  = ok ? (NUM_REG'(1) << d_arr[w]) : '0;
    x.cyc = ok ? 1 : 0;
    exp_q.push_back(x);
`ifdef BUS_XFER_RR_EN
    mptr = (w + 1) % NUM_REQ;
`endif
  endtask

  // Requesters all raised together and dropped on their own gnt: grant order follows the arbitration rule
  task automatic expect_batch(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] m;
    int w;
    m = mask;
    while (m != '0) begin
      w = pick(m);
      if (w < 0) break;
      push_exp(w);
      m &= ~(NUM_REQ'(1) << w);
    end
  endtask

  task automatic pack_idx();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_idx[i*IDX_W +: IDX_W] = IDX_W'(s_arr[i]);
      dst_idx[i*IDX_W +: IDX_W] = IDX_W'(d_arr[i]);
    end
  endtask

  task automatic wait_drain(input int budget, input string nm);
    for (int c = 0; c < budget && req != '0; c++) begin
      @(negedge clk);
      req = req & ~gnt;
    end
    post(nm, 32'(req), 32'd0);
  endtask

  initial begin
    int granted;
    logic [NUM_REQ-1:0] mask;
    rst = 1'b0;
    req = '0;
    src_idx = '0;
    dst_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_arr[i] = 0;
      d_arr[i] = 0;
    end
    repeat (3) @(negedge clk);
    post("reset_re", 32'(re), 32'd0);
    post("reset_we", 32'(we), 32'd0);
    post("reset_gnt", 32'(gnt), 32'd0);
    post("reset_err", 32'(err), 32'd0);
    post("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Valid move 2 -> 5 carrying 0xA5 through the bus model
    load_en = 1'b1; load_idx = 2; load_val = 8'hA5;
    @(negedge clk);
    load_en = 1'b0;
    s_arr[0] = 2; d_arr[0] = 5;
    pack_idx();
    expect_batch(4'b0001);
    req = 4'b0001;
    wait_drain(20, "drain_valid_move");
    @(negedge clk);
    post("reg5_after_move", 32'(regs[5]), 32'hA5);

    // src == dst is granted with err and no enables
    s_arr[1] = 3; d_arr[1] = 3;
    pack_idx();
    expect_batch(4'b0010);
    req = 4'b0010;
    wait_drain(20, "drain_invalid_move");
    @(negedge clk);

    // dst_idx changes after the request is latched
    s_arr[2] = 4; d_arr[2] = 1;
    pack_idx();
    expect_batch(4'b0100);
    req = 4'b0100;
    @(posedge clk);
    #1 dst_idx[2*IDX_W +: IDX_W] = 3'd6;
    wait_drain(20, "drain_dst_change");
    @(negedge clk);

    // Reset while re is active aborts the transfer without a grant
    s_arr[0] = 0; d_arr[0] = 7;
    pack_idx();
    req = 4'b0001;
    for (int c = 0; c < 10 && re == '0; c++) @(negedge clk);
    post("pre_reset_re", 32'(re), 32'h01);
    rst = 1'b0;
    #1;
    post("async_rst_re", 32'(re), 32'd0);
    post("async_rst_we", 32'(we), 32'd0);
    post("async_rst_gnt", 32'(gnt), 32'd0);
    post("async_rst_busy", 32'(busy), 32'd0);
    req = '0;
`ifdef BUS_XFER_RR_EN
    mptr = 0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // All requesters held high: five back-to-back grants, 3 cycles apart
    for (int i = 0; i < NUM_REQ; i++) begin
      s_arr[i] = i;
      d_arr[i] = i + 4;
    end
    pack_idx();
    for (int n = 0; n < 5; n++) push_exp(pick(4'b1111));
    spacing_chk = 1'b1;
    req = 4'b1111;
    granted = 0;
    for (int c = 0; c < 60 && granted < 5; c++) begin
      @(negedge clk);
      if (gnt != '0) granted++;
      if (granted == 5) req = '0;
    end
    req = '0;
    post("held_grant_count", 32'(granted), 32'd5);
    @(negedge clk);
    spacing_chk = 1'b0;
    @(negedge clk);

    // Randomized batches, including src == dst
    for (int b = 0; b < 120; b++) begin
      mask = NUM_REQ'($urandom_range(15, 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        s_arr[i] = int'($urandom_range(NUM_REG - 1, 0));
        if ($urandom_range(3, 0) == 0) d_arr[i] = s_arr[i];
        else                           d_arr[i] = int'($urandom_range(NUM_REG - 1, 0));
      end
      pack_idx();
      expect_batch(mask);
      req = mask;
      wait_drain(40, "drain_random");
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    post("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
